cpu_top: RTL and testbench

- Minimal 8-bit accumulator CPU core with X/Y index registers, 16-bit program counter and status flags.
- Fetches instructions byte-by-byte from an asynchronous-read 256-byte ROM.
- Reads and writes data through a 64 KB RAM port; RAM writes always source ACC.
- Top of the CPU hierarchy; exposes architectural state for debug and bench observation.

---
 rtl/cpu_top_if.sv | 22 ++
 rtl/cpu_top.sv | 193 +++++++++++++++++++
 tb/tb_cpu_top.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/cpu_top_if.sv
// Memory-side bus of the accumulator CPU: ROM fetch port, RAM port and the
// observable data/address bus.
interface cpu_top_if;
    logic [7:0]  data_bus;
    logic [15:0] addr_bus;
    logic        mem_read;
    logic        mem_write;
    logic [7:0]  rom_addr;
    logic [7:0]  rom_data;
    logic [15:0] ram_addr;
    logic [7:0]  ram_data;

    modport master (
        output data_bus, addr_bus, mem_read, mem_write, rom_addr, ram_addr,
        input  rom_data, ram_data
    );

    modport slave (
        input  data_bus, addr_bus, mem_read, mem_write, rom_addr, ram_addr,
        output rom_data, ram_data
    );
endinterface

// File: rtl/cpu_top.sv
// Minimal 8-bit accumulator CPU: byte-serial ROM fetch, absolute RAM load/store,
// X/Y index registers and C/Z/V/N flags.
module cpu_top (
    input  logic        clk,
    input  logic        reset,
    cpu_top_if.master   bus,
    output logic [7:0]  acc_out,
    output logic [15:0] pc_out,
    output logic [7:0]  flags_out,
    output logic [7:0]  x_out,
    output logic [7:0]  y_out,
    output logic        halt
);
    localparam logic [2:0] StFetch   = 3'd0;
    localparam logic [2:0] StOperand = 3'd1;
    localparam logic [2:0] StAddrHi  = 3'd2;
    localparam logic [2:0] StMem     = 3'd3;
    localparam logic [2:0] StHalted  = 3'd4;

    localparam logic [7:0] OpLdaImm = 8'h01;
    localparam logic [7:0] OpLdxImm = 8'h02;
    localparam logic [7:0] OpLdyImm = 8'h03;
    localparam logic [7:0] OpAddImm = 8'h04;
    localparam logic [7:0] OpSubImm = 8'h05;
    localparam logic [7:0] OpAndImm = 8'h06;
    localparam logic [7:0] OpOrImm  = 8'h07;
    localparam logic [7:0] OpXorImm = 8'h08;
    localparam logic [7:0] OpNot    = 8'h09;
    localparam logic [7:0] OpInc    = 8'h0A;
    localparam logic [7:0] OpDec    = 8'h0B;
    localparam logic [7:0] OpLdaAbs = 8'h0C;
    localparam logic [7:0] OpStaAbs = 8'h0D;
    localparam logic [7:0] OpJmpAbs = 8'h0E;
    localparam logic [7:0] OpHlt    = 8'hFF;

    logic [2:0]  r_state, w_state_nxt;
    logic [15:0] r_pc, w_pc_nxt;
    logic [7:0]  r_acc, w_acc_nxt;
    logic [7:0]  r_x, w_x_nxt;
    logic [7:0]  r_y, w_y_nxt;
    logic [7:0]  r_op, w_op_nxt;
    logic [7:0]  r_addr_lo, w_addr_lo_nxt;
    logic [7:0]  r_addr_hi, w_addr_hi_nxt;
    logic        r_c, w_c_nxt;
    logic        r_z, w_z_nxt;
    logic        r_v, w_v_nxt;
    logic        r_n, w_n_nxt;

    logic        w_upd_zn;
    logic [7:0]  w_zn_val;
    logic [15:0] w_pc_inc;

    // SUB is A + ~imm + 1, so both ops share one adder and overflow rule.
    logic        w_is_sub;
    logic [7:0]  w_b;
    logic [8:0]  w_sum;
    logic        w_ovf;

    assign w_is_sub = (r_op == OpSubImm);
    assign w_b      = w_is_sub ? ~bus.rom_data : bus.rom_data;
    assign w_sum    = {1'b0, r_acc} + {1'b0, w_b} + {8'd0, w_is_sub};
    assign w_ovf    = (r_acc[7] == w_b[7]) && (w_sum[7] != r_acc[7]);
    assign w_pc_inc = r_pc + 16'd1;

    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_acc_nxt     = r_acc;
        w_x_nxt       = r_x;
        w_y_nxt       = r_y;
        w_op_nxt      = r_op;
        w_addr_lo_nxt = r_addr_lo;
        w_addr_hi_nxt = r_addr_hi;
        w_c_nxt       = r_c;
        w_z_nxt       = r_z;
        w_v_nxt       = r_v;
        w_n_nxt       = r_n;
        w_upd_zn      = 1'b0;
        w_zn_val      = 8'h00;

        case (r_state)
            StFetch: begin
                w_op_nxt = bus.rom_data;
                w_pc_nxt = w_pc_inc;
                case (bus.rom_data)
                    OpNot: begin w_acc_nxt = ~r_acc;        w_upd_zn = 1'b1; end
                    OpInc: begin w_acc_nxt = r_acc + 8'd1;  w_upd_zn = 1'b1; end
                    OpDec: begin w_acc_nxt = r_acc - 8'd1;  w_upd_zn = 1'b1; end
                    OpHlt: w_state_nxt = StHalted;
                    OpLdaImm, OpLdxImm, OpLdyImm, OpAddImm, OpSubImm, OpAndImm,
                    OpOrImm, OpXorImm, OpLdaAbs, OpStaAbs, OpJmpAbs:
                        w_state_nxt = StOperand;
                    default: ;
                endcase
                w_zn_val = w_acc_nxt;
            end
            StOperand: begin
                w_pc_nxt    = w_pc_inc;
                w_state_nxt = StFetch;
                w_upd_zn    = 1'b1;
                case (r_op)
                    OpLdaImm: w_acc_nxt = bus.rom_data;
                    OpLdxImm: w_x_nxt   = bus.rom_data;
                    OpLdyImm: w_y_nxt   = bus.rom_data;
                    OpAddImm, OpSubImm: begin
                        w_acc_nxt = w_sum[7:0];
                        w_c_nxt   = w_sum[8];
                        w_v_nxt   = w_ovf;
                    end
                    OpAndImm: w_acc_nxt = r_acc & bus.rom_data;
                    OpOrImm:  w_acc_nxt = r_acc | bus.rom_data;
                    OpXorImm: w_acc_nxt = r_acc ^ bus.rom_data;
                    default: begin
                        w_upd_zn      = 1'b0;
                        w_addr_lo_nxt = bus.rom_data;
                        w_state_nxt   = StAddrHi;
                    end
                endcase
                w_zn_val = (r_op == OpLdxImm || r_op == OpLdyImm) ? bus.rom_data : w_acc_nxt;
            end
            StAddrHi: begin
                w_addr_hi_nxt = bus.rom_data;
                if (r_op == OpJmpAbs) begin
                    w_pc_nxt    = {bus.rom_data, r_addr_lo};
                    w_state_nxt = StFetch;
                end else begin
                    w_pc_nxt    = w_pc_inc;
                    w_state_nxt = StMem;
                end
            end
            StMem: begin
                if (r_op == OpLdaAbs) begin
                    w_acc_nxt = bus.ram_data;
                    w_upd_zn  = 1'b1;
                    w_zn_val  = bus.ram_data;
                end
                w_state_nxt = StFetch;
            end
            StHalted: ;
            default: w_state_nxt = StFetch;
        endcase

        if (w_upd_zn) begin
            w_z_nxt = (w_zn_val == 8'h00);
            w_n_nxt = w_zn_val[7];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= StFetch;
            r_pc      <= 16'h0000;
            r_acc     <= 8'h00;
            r_x       <= 8'h00;
            r_y       <= 8'h00;
            r_op      <= 8'h00;
            r_addr_lo <= 8'h00;
            r_addr_hi <= 8'h00;
            r_c       <= 1'b0;
            r_z       <= 1'b0;
            r_v       <= 1'b0;
            r_n       <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pc      <= w_pc_nxt;
            r_acc     <= w_acc_nxt;
            r_x       <= w_x_nxt;
            r_y       <= w_y_nxt;
            r_op      <= w_op_nxt;
            r_addr_lo <= w_addr_lo_nxt;
            r_addr_hi <= w_addr_hi_nxt;
            r_c       <= w_c_nxt;
            r_z       <= w_z_nxt;
            r_v       <= w_v_nxt;
            r_n       <= w_n_nxt;
        end
    end

    assign bus.rom_addr  = r_pc[7:0];
    assign bus.ram_addr  = {r_addr_hi, r_addr_lo};
    assign bus.addr_bus  = (r_state == StMem) ? {r_addr_hi, r_addr_lo} : r_pc;
    assign bus.mem_read  = (r_state == StMem) && (r_op == OpLdaAbs);
    assign bus.mem_write = (r_state == StMem) && (r_op == OpStaAbs);
    assign bus.data_bus  = bus.mem_read  ? bus.ram_data :
                           bus.mem_write ? r_acc : bus.rom_data;

    assign acc_out   = r_acc;
    assign pc_out    = r_pc;
    assign flags_out = {r_n, r_v, 4'b0000, r_z, r_c};
    assign x_out     = r_x;
    assign y_out     = r_y;
    assign halt      = (r_state == StHalted);
endmodule

// File: tb/tb_cpu_top.sv
// Directed bench for cpu_top: expected values are queued per program and popped
// as the CPU reaches each observation point.
module tb_cpu_top;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  acc_out, flags_out, x_out, y_out;
    logic [15:0] pc_out;
    logic        halt;

    logic [7:0]  rom [0:255];
    logic [7:0]  ram [0:65535];

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    cpu_top_if bus ();

    cpu_top dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .acc_out  (acc_out),
        .pc_out   (pc_out),
        .flags_out(flags_out),
        .x_out    (x_out),
        .y_out    (y_out),
        .halt     (halt)
    );

    assign bus.rom_data = rom[bus.rom_addr];
    assign bus.ram_data = ram[bus.ram_addr];

    always @(posedge clk) if (bus.mem_write) ram[bus.ram_addr] <= acc_out;

    always #5 clk = ~clk;

    task automatic push(input string t, input logic [31:0] v);
        exp_t e;
        e.tag = t;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic chk(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=%h", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val)
            else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    endtask

    task automatic release_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int steps[8];
        logic [7:0] accs[8];
        steps = '{2, 2, 2, 2, 2, 1, 1, 1};
        accs  = '{8'h5F, 8'h5A, 8'h5A, 8'h5F, 8'hA0, 8'h5F, 8'h60, 8'h5F};

        // Program A: ALU walk
        reset = 1'b1;
        clear_rom();
        rom[0]  = 8'h01; rom[1]  = 8'h55; rom[2]  = 8'h02; rom[3]  = 8'hAA;
        rom[4]  = 8'h03; rom[5]  = 8'h33; rom[6]  = 8'h04; rom[7]  = 8'h0A;
        rom[8]  = 8'h05; rom[9]  = 8'h05; rom[10] = 8'h06; rom[11] = 8'hFF;
        rom[12] = 8'h07; rom[13] = 8'h0F; rom[14] = 8'h08; rom[15] = 8'hFF;
        rom[16] = 8'h09; rom[17] = 8'h0A; rom[18] = 8'h0B;
        push("rst_pc", 32'h0000); push("rst_acc", 32'h00); push("rst_flags", 32'h00);
        push("rst_x", 32'h00); push("rst_y", 32'h00); push("rst_halt", 32'h0);
        push("rst_mem_read", 32'h0); push("rst_mem_write", 32'h0);
        push("a_lda", 32'h55); push("a_ldx", 32'hAA); push("a_ldy", 32'h33);
        for (int i = 0; i < 8; i++) push($sformatf("a_acc%0d", i), {24'd0, accs[i]});
        push("a_pc19", 32'h0013); push("a_pc20", 32'h0014);
        @(negedge clk);
        chk({16'd0, pc_out}); chk({24'd0, acc_out}); chk({24'd0, flags_out});
        chk({24'd0, x_out}); chk({24'd0, y_out}); chk({31'd0, halt});
        chk({31'd0, bus.mem_read}); chk({31'd0, bus.mem_write});
        release_reset();
        tick(2); chk({24'd0, acc_out});
        tick(2); chk({24'd0, x_out});
        tick(2); chk({24'd0, y_out});
        for (int i = 0; i < 8; i++) begin
            tick(steps[i]);
            chk({24'd0, acc_out});
        end
        chk({16'd0, pc_out});
        tick(1); chk({16'd0, pc_out});

        // Program B: carry, overflow, borrow, DEC keeps C
        reset = 1'b1;
        clear_rom();
        rom[0]  = 8'h01; rom[1]  = 8'hFF; rom[2]  = 8'h04; rom[3]  = 8'h01;
        rom[4]  = 8'h01; rom[5]  = 8'h7F; rom[6]  = 8'h04; rom[7]  = 8'h01;
        rom[8]  = 8'h01; rom[9]  = 8'h00; rom[10] = 8'h05; rom[11] = 8'h01;
        rom[12] = 8'h01; rom[13] = 8'hFF; rom[14] = 8'h04; rom[15] = 8'h01;
        rom[16] = 8'h01; rom[17] = 8'h00; rom[18] = 8'h0B; rom[19] = 8'hFF;
        push("b_add_wrap_acc", 32'h00); push("b_add_wrap_flags", 32'h03);
        push("b_lda7f_flags", 32'h01);
        push("b_ovf_acc", 32'h80); push("b_ovf_flags", 32'hC0);
        push("b_sub_acc", 32'hFF); push("b_sub_flags", 32'h80);
        push("b_add2_flags", 32'h03);
        push("b_dec_acc", 32'hFF); push("b_dec_flags", 32'h81);
        release_reset();
        tick(4); chk({24'd0, acc_out}); chk({24'd0, flags_out});
        tick(2); chk({24'd0, flags_out});
        tick(2); chk({24'd0, acc_out}); chk({24'd0, flags_out});
        tick(4); chk({24'd0, acc_out}); chk({24'd0, flags_out});
        tick(4); chk({24'd0, flags_out});
        tick(3); chk({24'd0, acc_out}); chk({24'd0, flags_out});

        // Program C: store then reload through RAM
        reset = 1'b1;
        clear_rom();
        rom[0] = 8'h01; rom[1] = 8'h3C; rom[2] = 8'h0D; rom[3]  = 8'h34;
        rom[4] = 8'h12; rom[5] = 8'h01; rom[6] = 8'h00; rom[7]  = 8'h0C;
        rom[8] = 8'h34; rom[9] = 8'h12; rom[10] = 8'hFF;
        push("c_lda", 32'h3C);
        push("c_sta_mem_write", 32'h1); push("c_sta_mem_read", 32'h0);
        push("c_sta_ram_addr", 32'h1234); push("c_sta_addr_bus", 32'h1234);
        push("c_sta_data_bus", 32'h3C);
        push("c_ram_1234", 32'h3C); push("c_post_mem_write", 32'h0);
        push("c_lda0", 32'h00);
        push("c_lda_mem_read", 32'h1); push("c_lda_mem_write", 32'h0);
        push("c_lda_data_bus", 32'h3C); push("c_lda_addr_bus", 32'h1234);
        push("c_final_acc", 32'h3C); push("c_final_flags", 32'h00);
        release_reset();
        tick(2); chk({24'd0, acc_out});
        tick(3);
        chk({31'd0, bus.mem_write}); chk({31'd0, bus.mem_read});
        chk({16'd0, bus.ram_addr}); chk({16'd0, bus.addr_bus}); chk({24'd0, bus.data_bus});
        tick(1); chk({24'd0, ram[16'h1234]}); chk({31'd0, bus.mem_write});
        tick(2); chk({24'd0, acc_out});
        tick(3);
        chk({31'd0, bus.mem_read}); chk({31'd0, bus.mem_write});
        chk({24'd0, bus.data_bus}); chk({16'd0, bus.addr_bus});
        tick(1); chk({24'd0, acc_out}); chk({24'd0, flags_out});

        // Program D: jump then halt, state frozen
        reset = 1'b1;
        clear_rom();
        rom[0] = 8'h01; rom[1] = 8'h77; rom[2] = 8'h02; rom[3] = 8'h12;
        rom[4] = 8'h0E; rom[5] = 8'h40; rom[6] = 8'h00; rom[8'h40] = 8'hFF;
        push("d_jmp_pc", 32'h0040); push("d_jmp_halt", 32'h0);
        push("d_hlt_pc", 32'h0041); push("d_hlt_halt", 32'h1);
        push("d_frozen_pc", 32'h0041); push("d_frozen_halt", 32'h1);
        push("d_frozen_acc", 32'h77); push("d_frozen_x", 32'h12);
        release_reset();
        tick(4);
        tick(3); chk({16'd0, pc_out}); chk({31'd0, halt});
        tick(1); chk({16'd0, pc_out}); chk({31'd0, halt});
        tick(10);
        chk({16'd0, pc_out}); chk({31'd0, halt}); chk({24'd0, acc_out}); chk({24'd0, x_out});

        // Program E: reset in the operand cycle of ADD#05
        reset = 1'b1;
        clear_rom();
        rom[0] = 8'h01; rom[1] = 8'h10; rom[2] = 8'h04; rom[3] = 8'h05; rom[4] = 8'hFF;
        push("e_lda", 32'h10); push("e_operand_pc", 32'h0003);
        push("e_async_acc", 32'h00); push("e_async_pc", 32'h0000);
        push("e_async_halt", 32'h0);
        push("e_restart_acc", 32'h10); push("e_restart_pc", 32'h0002);
        push("e_add_acc", 32'h15); push("e_add_pc", 32'h0004);
        release_reset();
        tick(2); chk({24'd0, acc_out});
        tick(1); chk({16'd0, pc_out});
        reset = 1'b1;
        #1;
        chk({24'd0, acc_out}); chk({16'd0, pc_out}); chk({31'd0, halt});
        release_reset();
        tick(2); chk({24'd0, acc_out}); chk({16'd0, pc_out});
        tick(2); chk({24'd0, acc_out}); chk({16'd0, pc_out});

        if (sb.size() != 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
